// File: rtl/sram_pkg.sv
// Shared constants and types for the SRAM arbiter / ZBT controller path.
// SRAM_READ_LATENCY is also the depth of the arbiter's read-port tag pipeline,
// so both ends agree on when returned data belongs to which requester.
package sram_pkg;

    localparam int unsigned SRAM_ADDR_W        = 18;
    localparam int unsigned SRAM_DATA_W        = 32;
    localparam int unsigned SRAM_MASK_W        = 4;
    localparam int unsigned SRAM_READ_LATENCY  = 3;
    localparam int unsigned SRAM_WR_PIPE_DEPTH = 2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } sram_state_e;

endpackage

// File: rtl/sram_delay_line.sv
// Fixed-depth register chain with asynchronous active-low clear.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low clear of every stage
//   d     - input word, captured into stage 0 on each rising edge
//   q     - output of the last stage (d delayed by DEPTH edges)
module sram_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = d;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/sram_zbt_controller.sv
// Responder side of the arbiter-to-SRAM request interface, driving a
// pipelined ZBT SRAM. One read or masked write is accepted per cycle; read
// data returns in order exactly SRAM_READ_LATENCY edges after acceptance.
// Ports:
//   sram_clock, reset_n            - clock, asynchronous active-low reset
//   sram_addr_valid / sram_ready   - request handshake
//   sram_addr, sram_data_in        - request address and write data
//   sram_write_mask                - 0 = read, else per-byte write enables
//   sram_data_out(_valid)          - read data and its one-cycle strobe
//   zbt_*                          - SRAM pins; DQ split into out/oe/in for
//                                    the top-level tristate buffer
module sram_zbt_controller
    import sram_pkg::*;
#(
    parameter int unsigned INIT_CYCLES = 16
) (
    input  logic                   sram_clock,
    input  logic                   reset_n,
    input  logic                   sram_addr_valid,
    output logic                   sram_ready,
    input  logic [SRAM_ADDR_W-1:0] sram_addr,
    input  logic [SRAM_DATA_W-1:0] sram_data_in,
    input  logic [SRAM_MASK_W-1:0] sram_write_mask,
    output logic [SRAM_DATA_W-1:0] sram_data_out,
    output logic                   sram_data_out_valid,
    output logic [SRAM_ADDR_W-1:0] zbt_addr,
    output logic                   zbt_ce_b,
    output logic                   zbt_we_b,
    output logic                   zbt_adv_ld_b,
    output logic [SRAM_MASK_W-1:0] zbt_bw_b,
    output logic                   zbt_oe_b,
    output logic [SRAM_DATA_W-1:0] zbt_dq_out,
    output logic                   zbt_dq_oe,
    input  logic [SRAM_DATA_W-1:0] zbt_dq_in
);

    localparam int unsigned CNT_W = (INIT_CYCLES < 2) ? 1 : $clog2(INIT_CYCLES + 1);

    sram_state_e             state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [SRAM_ADDR_W-1:0]  zbt_addr_q, zbt_addr_d;
    logic                    zbt_ce_b_q, zbt_ce_b_d;
    logic                    zbt_we_b_q, zbt_we_b_d;
    logic [SRAM_MASK_W-1:0]  zbt_bw_b_q, zbt_bw_b_d;
    logic                    zbt_oe_b_q, zbt_oe_b_d;
    logic [SRAM_DATA_W-1:0]  zbt_dq_out_q, zbt_dq_out_d;
    logic                    zbt_dq_oe_q, zbt_dq_oe_d;
    logic [SRAM_DATA_W-1:0]  data_out_q, data_out_d;
    logic                    data_out_valid_q, data_out_valid_d;

    logic                    accept;
    logic                    is_write;
    logic                    is_read;
    logic [SRAM_DATA_W:0]    wr_pipe_in;
    logic [SRAM_DATA_W:0]    wr_pipe_out;
    logic                    rd_tag_out;

    assign sram_ready = (state_q == ST_RUN);
    assign accept     = sram_addr_valid && sram_ready;
    assign is_write   = accept && (sram_write_mask != '0);
    assign is_read    = accept && (sram_write_mask == '0);

    // Power-up counter: leaving INIT on the edge where the count is 1 makes
    // sram_ready rise exactly INIT_CYCLES edges after reset release.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (state_q == ST_INIT) begin
            if (count_q <= CNT_W'(1)) begin
                state_d = ST_RUN;
                count_d = '0;
            end else begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_comb begin
        zbt_addr_d = accept ? sram_addr : zbt_addr_q;
        zbt_ce_b_d = !accept;
        zbt_we_b_d = !is_write;
        zbt_bw_b_d = is_write ? ~sram_write_mask : '1;
        zbt_oe_b_d = (state_d != ST_RUN);
        wr_pipe_in = {is_write, (is_write ? sram_data_in : '0)};
    end

    // Write data crosses two pipe stages plus the DQ output register, so it
    // sits on the bus during the cycle the SRAM's late-write captures it.
    sram_delay_line #(
        .WIDTH(SRAM_DATA_W + 1),
        .DEPTH(SRAM_WR_PIPE_DEPTH)
    ) u_wr_pipe (
        .clk  (sram_clock),
        .rst_n(reset_n),
        .d    (wr_pipe_in),
        .q    (wr_pipe_out)
    );

    sram_delay_line #(
        .WIDTH(1),
        .DEPTH(SRAM_READ_LATENCY)
    ) u_rd_tag (
        .clk  (sram_clock),
        .rst_n(reset_n),
        .d    (is_read),
        .q    (rd_tag_out)
    );

    always_comb begin
        zbt_dq_oe_d      = wr_pipe_out[SRAM_DATA_W];
        zbt_dq_out_d     = wr_pipe_out[SRAM_DATA_W-1:0];
        data_out_valid_d = rd_tag_out;
        data_out_d       = rd_tag_out ? zbt_dq_in : data_out_q;
    end

    always_ff @(posedge sram_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_INIT;
            count_q          <= CNT_W'(INIT_CYCLES);
            zbt_addr_q       <= '0;
            zbt_ce_b_q       <= 1'b1;
            zbt_we_b_q       <= 1'b1;
            zbt_bw_b_q       <= '1;
            zbt_oe_b_q       <= 1'b1;
            zbt_dq_out_q     <= '0;
            zbt_dq_oe_q      <= 1'b0;
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            count_q          <= count_d;
            zbt_addr_q       <= zbt_addr_d;
            zbt_ce_b_q       <= zbt_ce_b_d;
            zbt_we_b_q       <= zbt_we_b_d;
            zbt_bw_b_q       <= zbt_bw_b_d;
            zbt_oe_b_q       <= zbt_oe_b_d;
            zbt_dq_out_q     <= zbt_dq_out_d;
            zbt_dq_oe_q      <= zbt_dq_oe_d;
            data_out_q       <= data_out_d;
            data_out_valid_q <= data_out_valid_d;
        end
    end

    assign zbt_addr            = zbt_addr_q;
    assign zbt_ce_b            = zbt_ce_b_q;
    assign zbt_we_b            = zbt_we_b_q;
    assign zbt_adv_ld_b        = 1'b0;
    assign zbt_bw_b            = zbt_bw_b_q;
    assign zbt_oe_b            = zbt_oe_b_q;
    assign zbt_dq_out          = zbt_dq_out_q;
    assign zbt_dq_oe           = zbt_dq_oe_q;
    assign sram_data_out       = data_out_q;
    assign sram_data_out_valid = data_out_valid_q;

endmodule

// File: tb/tb_sram_zbt_controller.sv
// Self-checking bench for sram_zbt_controller: a pin-level ZBT memory model
// answers the DUT, while an abstract word-memory model predicts every output.
module tb_sram_zbt_controller;

    localparam int unsigned INIT = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sram_addr_valid;
    logic        sram_ready;
    logic [17:0] sram_addr;
    logic [31:0] sram_data_in;
    logic [3:0]  sram_write_mask;
    logic [31:0] sram_data_out;
    logic        sram_data_out_valid;
    logic [17:0] zbt_addr;
    logic        zbt_ce_b;
    logic        zbt_we_b;
    logic        zbt_adv_ld_b;
    logic [3:0]  zbt_bw_b;
    logic        zbt_oe_b;
    logic [31:0] zbt_dq_out;
    logic        zbt_dq_oe;
    logic [31:0] zbt_dq_in;

    sram_zbt_controller #(.INIT_CYCLES(INIT)) dut (
        .sram_clock         (clk),
        .reset_n            (reset_n),
        .sram_addr_valid    (sram_addr_valid),
        .sram_ready         (sram_ready),
        .sram_addr          (sram_addr),
        .sram_data_in       (sram_data_in),
        .sram_write_mask    (sram_write_mask),
        .sram_data_out      (sram_data_out),
        .sram_data_out_valid(sram_data_out_valid),
        .zbt_addr           (zbt_addr),
        .zbt_ce_b           (zbt_ce_b),
        .zbt_we_b           (zbt_we_b),
        .zbt_adv_ld_b       (zbt_adv_ld_b),
        .zbt_bw_b           (zbt_bw_b),
        .zbt_oe_b           (zbt_oe_b),
        .zbt_dq_out         (zbt_dq_out),
        .zbt_dq_oe          (zbt_dq_oe),
        .zbt_dq_in          (zbt_dq_in)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rel_edges = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) rel_edges <= 0;
        else          rel_edges <= rel_edges + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- abstract reference model ----------------
    typedef struct {
        bit          w;
        logic [17:0] a;
        logic [3:0]  m;
    } req_t;

    logic [31:0] ref_mem [256];
    req_t        pin_exp [int];   // keyed by acceptance edge
    logic [31:0] wr_exp  [int];   // write data expected on DQ, keyed by edge
    logic [31:0] rd_exp  [int];   // read data expected at output, keyed by edge
    logic [17:0] last_addr = '0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (m[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    // ---------------- pin-level ZBT memory model ----------------
    typedef struct {
        bit          v;
        bit          w;
        logic [17:0] a;
        logic [3:0]  bw;
    } pin_t;

    logic [31:0] zbt_mem [256];
    pin_t        ring [8];

    always @(negedge clk) begin
        pin_t s;
        ring[cyc % 8] = '{v: !zbt_ce_b, w: !zbt_we_b, a: zbt_addr, bw: zbt_bw_b};
        s = ring[(cyc + 6) % 8];
        if (s.v && s.w)
            zbt_mem[s.a[7:0]] = merge(zbt_mem[s.a[7:0]],
                                      zbt_dq_oe ? zbt_dq_out : 32'h0BAD_F00D, ~s.bw);
        if (s.v && !s.w) zbt_dq_in = zbt_mem[s.a[7:0]];
        else             zbt_dq_in = $urandom;
    end

    // ---------------- per-cycle output monitor ----------------
    always @(negedge clk) begin
        chk("adv_ld_b", 64'(zbt_adv_ld_b), 64'd0);
        if (!reset_n) begin
            last_addr = '0;
            chk("rst_ready", 64'(sram_ready), 64'd0);
            chk("rst_pins", {zbt_ce_b, zbt_we_b, zbt_bw_b, zbt_oe_b, zbt_addr},
                {1'b1, 1'b1, 4'hF, 1'b1, 18'h0});
            chk("rst_dq", {zbt_dq_oe, zbt_dq_out}, 64'd0);
            chk("rst_out", {sram_data_out_valid, sram_data_out}, 64'd0);
        end else begin
            bit rdy;
            rdy = (rel_edges >= INIT);
            chk("ready", 64'(sram_ready), 64'(rdy));
            chk("oe_b", 64'(zbt_oe_b), 64'(!rdy));
            if (pin_exp.exists(cyc)) begin
                req_t r;
                r = pin_exp[cyc];
                last_addr = r.a;
                chk("pins_req", {zbt_ce_b, zbt_we_b, zbt_bw_b, zbt_addr},
                    {1'b0, !r.w, (r.w ? ~r.m : 4'hF), r.a});
                pin_exp.delete(cyc);
            end else begin
                chk("pins_idle", {zbt_ce_b, zbt_we_b, zbt_bw_b, zbt_addr},
                    {1'b1, 1'b1, 4'hF, last_addr});
            end
            if (wr_exp.exists(cyc)) begin
                chk("dq_write", {zbt_dq_oe, zbt_dq_out}, {1'b1, wr_exp[cyc]});
                wr_exp.delete(cyc);
            end else begin
                chk("dq_oe_idle", 64'(zbt_dq_oe), 64'd0);
            end
            if (rd_exp.exists(cyc)) begin
                chk("rd_data", {sram_data_out_valid, sram_data_out}, {1'b1, rd_exp[cyc]});
                rd_exp.delete(cyc);
            end else begin
                chk("rd_valid_idle", 64'(sram_data_out_valid), 64'd0);
            end
        end
    end

    // ---------------- driver ----------------
    // Called just after a rising edge; the request is presented for one cycle
    // and is accepted at the next edge if the model says the block is ready.
    task automatic issue(input bit v, input bit w, input logic [17:0] a,
                         input logic [31:0] d, input logic [3:0] m,
                         input bit use_exp, input logic [31:0] exp_d);
        int k;
        sram_addr_valid = v;
        sram_addr       = a;
        sram_data_in    = d;
        sram_write_mask = w ? m : 4'h0;
        if (v && rel_edges >= INIT) begin
            k = cyc + 1;
            pin_exp[k] = '{w: w, a: a, m: m};
            if (w) begin
                wr_exp[k + 2] = d;
                ref_mem[a[7:0]] = merge(ref_mem[a[7:0]], d, m);
            end else begin
                rd_exp[k + 3] = use_exp ? exp_d : ref_mem[a[7:0]];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(1'b0, 1'b0, 18'h0, 32'h0, 4'h0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        sram_addr_valid = 1'b0;
        reset_n = 1'b0;
        pin_exp.delete();
        wr_exp.delete();
        rd_exp.delete();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    typedef struct {
        bit          v;
        bit          w;
        logic [17:0] a;
        logic [31:0] d;
        logic [3:0]  m;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [$];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = '0;
            zbt_mem[i] = '0;
        end
        for (int i = 0; i < 8; i++) ring[i] = '{v: 1'b0, w: 1'b0, a: '0, bw: 4'hF};
        zbt_dq_in       = '0;
        sram_addr_valid = 1'b0;
        sram_addr       = '0;
        sram_data_in    = '0;
        sram_write_mask = '0;

        tbl.push_back('{1, 1, 18'h10, 32'hDEADBEEF, 4'hF, 32'h0});
        tbl.push_back('{0, 0, 18'h0,  32'h0,        4'h0, 32'h0});
        tbl.push_back('{1, 0, 18'h10, 32'h0,        4'h0, 32'hDEADBEEF});
        tbl.push_back('{0, 0, 18'h0,  32'h0,        4'h0, 32'h0});
        tbl.push_back('{1, 1, 18'h5,  32'hAAAAAAAA, 4'hF, 32'h0});
        tbl.push_back('{1, 1, 18'h5,  32'h11223344, 4'h5, 32'h0});
        tbl.push_back('{1, 0, 18'h5,  32'h0,        4'h0, 32'hAA22AA44});
        tbl.push_back('{1, 1, 18'h2,  32'h22222222, 4'hF, 32'h0});
        tbl.push_back('{1, 1, 18'h4,  32'h44444444, 4'hF, 32'h0});
        tbl.push_back('{1, 1, 18'h1,  32'h11111111, 4'hF, 32'h0});
        tbl.push_back('{1, 0, 18'h2,  32'h0,        4'h0, 32'h22222222});
        tbl.push_back('{1, 1, 18'h3,  32'h33333333, 4'hF, 32'h0});
        tbl.push_back('{1, 0, 18'h4,  32'h0,        4'h0, 32'h44444444});
        tbl.push_back('{1, 0, 18'h1,  32'h0,        4'h0, 32'h11111111});
        tbl.push_back('{1, 0, 18'h3,  32'h0,        4'h0, 32'h33333333});
        tbl.push_back('{1, 0, 18'h10, 32'h0,        4'h0, 32'hDEADBEEF});
        tbl.push_back('{1, 0, 18'h5,  32'h0,        4'h0, 32'hAA22AA44});

        // Init: requests offered during INIT must be ignored.
        do_reset();
        for (int i = 0; i < 20; i++)
            issue(i[0], 1'b1, 18'h3F, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0);

        foreach (tbl[i])
            issue(tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].m, 1'b1, tbl[i].exp_rd);
        idle(5);

        for (int i = 0; i < 400; i++) begin
            bit          v, w;
            logic [3:0]  m;
            v = ($urandom_range(0, 3) != 0);
            w = $urandom_range(0, 1);
            m = 4'($urandom_range(1, 15));
            issue(v, w, 18'($urandom_range(0, 15)), $urandom, m, 1'b0, 32'h0);
        end
        idle(5);

        // Reset with two reads in flight: nothing may come back.
        issue(1'b1, 1'b0, 18'h10, 32'h0, 4'h0, 1'b0, 32'h0);
        issue(1'b1, 1'b0, 18'h5,  32'h0, 4'h0, 1'b0, 32'h0);
        sram_addr_valid = 1'b0;
        reset_n = 1'b0;
        pin_exp.delete();
        wr_exp.delete();
        rd_exp.delete();
        #1;
        chk("midrst_dq_oe", 64'(zbt_dq_oe), 64'd0);
        chk("midrst_valid", 64'(sram_data_out_valid), 64'd0);
        chk("midrst_ready", 64'(sram_ready), 64'd0);
        chk("midrst_ce_b", 64'(zbt_ce_b), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++)
            issue(1'b1, 1'b0, 18'h10, 32'h0, 4'h0, 1'b0, 32'h0);
        issue(1'b1, 1'b0, 18'h10, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF);
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
